// File: rtl/led_chain_driver_pkg.sv
// Shared types and constants for the LED chain driver.
package led_chain_driver_pkg;

  // Channels on one LED driver board.
  localparam int unsigned ChPerBoard = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StLatch
  } state_e;

  // Clocks needed to stream and latch one complete frame.
  function automatic int unsigned frame_len(input int unsigned ch, input int unsigned bpc,
                                            input int unsigned lat_cycles);
    return ch * (2 + 2 * bpc) + lat_cycles + 1;
  endfunction

endpackage

// File: rtl/led_chain_driver_frame_timer.sv
// Free-running frame timer: counts 0..c_period-1 while enabled and ticks on the wrap.
// Disabling clears and holds the count.
module led_chain_driver_frame_timer #(
  parameter int unsigned c_period = 16666
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CntW = (c_period > 1) ? $clog2(c_period) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(c_period - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && (cnt_q == LastCnt);

  // Next count: wrap on tick, clear while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_en || o_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chain_driver.sv
// Streams one frame per timer tick into c_chains parallel daisy-chained LED driver strings
// sharing one shift clock and one latch. Channels go out highest address first.
// Optional feature: define DRIVER_BLANK_EN to add o_blank (high through the latch window
// plus one clock, and while in reset).
module led_chain_driver
  import led_chain_driver_pkg::*;
#(
  parameter int unsigned c_chains       = 2,
  parameter int unsigned c_ledboards    = 15,
  parameter int unsigned c_ch           = c_ledboards * ChPerBoard,
  parameter int unsigned c_bpc          = 12,
  parameter int unsigned c_frame_period = 16666,
  parameter int unsigned c_lat_cycles   = 2,
  // Lets a deliberately short period elaborate so tick overruns can be exercised.
  parameter bit          c_allow_overrun = 1'b0,
  localparam int unsigned c_addr_w      = (c_ch > 1) ? $clog2(c_ch) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [c_chains*c_bpc-1:0] i_data,
  output logic [c_addr_w-1:0]       o_addr,
  output logic                      o_rd,
  output logic                      o_sclk,
  output logic [c_chains-1:0]       o_dai,
  output logic                      o_lat,
  output logic                      o_frame_done,
`ifdef DRIVER_BLANK_EN
  output logic                      o_blank,
`endif
  output logic                      o_overrun
);

  localparam int unsigned BitW = (c_bpc > 1) ? $clog2(c_bpc) : 1;
  localparam int unsigned LatW = (c_lat_cycles > 1) ? $clog2(c_lat_cycles) : 1;
  localparam logic [c_addr_w-1:0] LastCh  = c_addr_w'(c_ch - 1);
  localparam logic [BitW-1:0]     LastBit = BitW'(c_bpc - 1);
  localparam logic [LatW-1:0]     LastLat = LatW'(c_lat_cycles - 1);

  if (!c_allow_overrun && (c_frame_period < frame_len(c_ch, c_bpc, c_lat_cycles)))
  begin : g_bad_period
    $error("c_frame_period is shorter than one frame");
  end
  if (c_lat_cycles < 1) begin : g_bad_lat
    $error("c_lat_cycles must be at least 1");
  end

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [c_addr_w-1:0] ch_q, ch_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic                phase_q, phase_d;
  logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [c_addr_w-1:0] addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic [c_chains-1:0] dai_q, dai_d;
  logic                load, shift, tick;

  led_chain_driver_frame_timer #(
    .c_period(c_frame_period)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en),
    .o_tick (tick)
  );

  // Sequencer next state: fetch/load/shift per channel, then latch the whole frame.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ch_d      = ch_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    sclk_d    = 1'b0;
    lat_d     = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    // A tick that finds one already pending is dropped, not queued.
    ovr_d     = tick && pending_q;
    if (tick && !pending_q) begin
      pending_d = 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (pending_q) begin
          pending_d = 1'b0;
          ch_d      = LastCh;
          addr_d    = LastCh;
          rd_d      = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        load    = 1'b1;
        bit_d   = '0;
        phase_d = 1'b0;
        state_d = StShift;
      end
      StShift: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (bit_q != LastBit) begin
            bit_d = bit_q + BitW'(1);
            shift = 1'b1;
          end else if (ch_q != '0) begin
            ch_d    = ch_q - c_addr_w'(1);
            addr_d  = ch_q - c_addr_w'(1);
            rd_d    = 1'b1;
            state_d = StFetch;
          end else begin
            lat_d     = 1'b1;
            done_d    = 1'b1;
            lat_cnt_d = '0;
            state_d   = StLatch;
          end
        end
      end
      StLatch: begin
        if (lat_cnt_q == LastLat) begin
          state_d = StIdle;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
          lat_d     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-string shift registers; serial data is forced low outside SHIFT.
  for (genvar k = 0; k < c_chains; k++) begin : g_chain
    logic [c_bpc-1:0] sr_q, sr_d;

    assign sr_d = load  ? i_data[k*c_bpc +: c_bpc] :
                  shift ? (sr_q << 1) : sr_q;
    assign dai_d[k] = (state_d == StShift) ? sr_d[c_bpc-1] : 1'b0;

    // Shift register state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      ch_q      <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      sclk_q    <= 1'b0;
      lat_q     <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      dai_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ch_q      <= ch_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      sclk_q    <= sclk_d;
      lat_q     <= lat_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      dai_q     <= dai_d;
    end
  end

`ifdef DRIVER_BLANK_EN
  logic blank_q, blank_d;

  // Blank spans the latch pulse plus one clock after it falls.
  assign blank_d = lat_d | lat_q;

  // Blank register; held high through reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blank_q <= 1'b1;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign o_blank = blank_q;
`endif

  assign o_addr       = addr_q;
  assign o_rd         = rd_q;
  assign o_sclk       = sclk_q;
  assign o_dai        = dai_q;
  assign o_lat        = lat_q;
  assign o_frame_done = done_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_led_chain_driver.sv
// Bench for led_chain_driver: a small framebuffer model pushes the expected serial bits of each
// fetched channel into a scoreboard that is popped on every shift-clock rise.
module tb_led_chain_driver;

  localparam int unsigned Chains = 2;
  localparam int unsigned Bpc    = 4;
  localparam int unsigned Ch     = 4;
  localparam int unsigned Period = 64;
  localparam int unsigned Lat    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic                  en_ovr;
  logic [Chains*Bpc-1:0] rdata = '0;
  logic [1:0]            addr;
  logic                  rd, sclk, lat, done, ovr;
  logic [Chains-1:0]     dai;
  logic [Chains*Bpc-1:0] rdata_ovr = '0;
  logic [1:0]            addr_ovr;
  logic                  rd_ovr, sclk_ovr, lat_ovr, done_ovr, ovr_ovr;
  logic [Chains-1:0]     dai_ovr;
`ifdef DRIVER_BLANK_EN
  logic                  blank, blank_ovr;
`endif

  always #5 clk = ~clk;

  led_chain_driver #(
    .c_chains(Chains), .c_ledboards(1), .c_ch(Ch), .c_bpc(Bpc),
    .c_frame_period(Period), .c_lat_cycles(Lat)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(rdata), .o_addr(addr), .o_rd(rd),
    .o_sclk(sclk), .o_dai(dai), .o_lat(lat), .o_frame_done(done),
`ifdef DRIVER_BLANK_EN
    .o_blank(blank),
`endif
    .o_overrun(ovr)
  );

  led_chain_driver #(
    .c_chains(Chains), .c_ledboards(1), .c_ch(Ch), .c_bpc(Bpc),
    .c_frame_period(40), .c_lat_cycles(Lat), .c_allow_overrun(1'b1)
  ) dut_ovr (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_ovr), .i_data(rdata_ovr), .o_addr(addr_ovr),
    .o_rd(rd_ovr), .o_sclk(sclk_ovr), .o_dai(dai_ovr), .o_lat(lat_ovr),
    .o_frame_done(done_ovr),
`ifdef DRIVER_BLANK_EN
    .o_blank(blank_ovr),
`endif
    .o_overrun(ovr_ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Edge count since reset release; sampled at negedge it equals the number of edges seen.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Framebuffer model: ch[n] = {B: ~(n+1), A: n+1}; pushes the expected bits MSB first.
  logic [1:0] exp_q[$];
  logic [3:0] mv;
  always @(posedge clk) begin
    if (rd) begin
      mv = 4'(addr) + 4'd1;
      rdata <= {~mv, mv};
      for (int b = Bpc - 1; b >= 0; b--) exp_q.push_back({~mv[b], mv[b]});
    end
  end

  // Output monitor for the main instance.
  logic       sclk_prev, lat_prev;
  logic [1:0] exp_bits;
  int rises, lat_len, exp_addr, rd_total = 0, done_cnt = 0, last_done_cyc = -1;
  int first_rd_cyc = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      sclk_prev = 1'b0;
      lat_prev  = 1'b0;
      rises     = 0;
      lat_len   = 0;
      exp_addr  = Ch - 1;
`ifdef DRIVER_BLANK_EN
      check_eq("blank_in_reset", 32'(blank), 32'd1);
`endif
    end else begin
      if (rd) begin
        check_eq("addr_seq", 32'(addr), 32'(exp_addr));
        exp_addr = (exp_addr == 0) ? Ch - 1 : exp_addr - 1;
        rd_total++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (sclk && !sclk_prev) begin
        rises++;
        if (exp_q.size() == 0) begin
          check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_bits = exp_q.pop_front();
          check_eq("dai_bits", 32'(dai), 32'(exp_bits));
        end
      end
      if (lat) begin
        lat_len++;
        check_eq("dai_zero_in_latch", 32'(dai), 32'd0);
      end
      if (!lat && lat_prev) begin
        check_eq("lat_len", 32'(lat_len), 32'(Lat));
        lat_len = 0;
      end
      if (done) begin
        check_eq("sclk_rises", 32'(rises), 32'(Ch * Bpc));
        check_eq("done_with_lat", 32'(lat), 32'd1);
        rises = 0;
        done_cnt++;
        last_done_cyc = cyc;
      end
`ifdef DRIVER_BLANK_EN
      check_eq("blank_window", 32'(blank), 32'(lat | lat_prev));
`endif
      sclk_prev = sclk;
      lat_prev  = lat;
    end
  end

  // Monitor for the short-period instance: frames keep full length and run back to back.
  int ovr_pulses = 0, ovr_start = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      ovr_start = -1;
    end else begin
      if (ovr_ovr) ovr_pulses++;
      if (rd_ovr && addr_ovr == 2'(Ch - 1)) begin
        if (ovr_start >= 0) check_eq("ovr_frame_gap", 32'(cyc - ovr_start), 32'd43);
        ovr_start = cyc;
      end
      if (done_ovr && ovr_start >= 0) begin
        check_eq("ovr_frame_len", 32'(cyc - ovr_start), 32'd40);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound);
    int start;
    start = done_cnt;
    for (int i = 0; i < bound && done_cnt == start; i++) tick();
    check_eq("done_seen", 32'(done_cnt != start), 32'd1);
  endtask

  int c0, n_rd;

  initial begin
    rst_n  = 1'b1;
    en     = 1'b0;
    en_ovr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_dai", 32'(dai), 32'd0);
    check_eq("rst_lat", 32'(lat), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);

    // First frame after release: timing, addresses and bitstream.
    first_rd_cyc = -1;
    rst_n = 1'b1;
    en    = 1'b1;
    wait_done(200);
    check_eq("first_rd_cyc", 32'(first_rd_cyc), 32'd65);
    check_eq("first_done_cyc", 32'(last_done_cyc), 32'd105);

    // Drop enable mid-SHIFT of the second frame: it still completes.
    for (int i = 0; i < 200 && cyc < 145; i++) tick();
    en = 1'b0;
    wait_done(100);
    check_eq("done_after_drop", 32'(last_done_cyc), 32'd169);
    n_rd = rd_total;
    repeat (150) tick();
    check_eq("no_rd_disabled", 32'(rd_total), 32'(n_rd));
    c0 = cyc;
    first_rd_cyc = -1;
    en = 1'b1;
    wait_done(200);
    check_eq("rd_after_reenable", 32'(first_rd_cyc - c0), 32'd65);
    en = 1'b0;

    // Short-period instance must drop a tick while one is pending.
    en_ovr = 1'b1;
    for (int i = 0; i < 2000 && ovr_pulses == 0; i++) tick();
    check_eq("overrun_seen", 32'(ovr_pulses > 0), 32'd1);
    en_ovr = 1'b0;
    repeat (100) tick();

    // Reset mid-SHIFT clears outputs immediately; a clean frame follows.
    c0 = cyc;
    en = 1'b1;
    for (int i = 0; i < 300 && !(sclk && cyc > c0 + 70); i++) tick();
    check_eq("sclk_high_before_rst", 32'(sclk), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mid_dai", 32'(dai), 32'd0);
    check_eq("rst_mid_lat", 32'(lat), 32'd0);
    check_eq("rst_mid_rd", 32'(rd), 32'd0);
`ifdef DRIVER_BLANK_EN
    check_eq("rst_mid_blank", 32'(blank), 32'd1);
`endif
    repeat (3) tick();
    first_rd_cyc = -1;
    rst_n = 1'b1;
    wait_done(200);
    check_eq("post_rst_first_rd", 32'(first_rd_cyc), 32'd65);
    check_eq("post_rst_done", 32'(last_done_cyc), 32'd105);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
